// File: rtl/approx_sweep_pkg.sv
// Shared types and width helpers for the approximate-multiplier error sweep.
// The state enum and DRAIN_CYCLES are used by the FSM; the width functions size the interface and datapath.
package approx_sweep_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  localparam int DRAIN_CYCLES = 2;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int count_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int sum_w(input int w);
    return 4 * w;
  endfunction

endpackage

// File: rtl/approx_err_sweep_if.sv
// Control/result bundle of approx_err_sweep; trace signals exist only with APPROX_SWEEP_TRACE_EN.
// slave = engine side, master = consumer side.
interface approx_err_sweep_if
  import approx_sweep_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic                        start_in;
  logic                        busy_out;
  logic                        done_out;
  logic [count_w(WIDTH)-1:0]   err_count_out;
  logic [sum_w(WIDTH)-1:0]     sum_err_out;
  logic [prod_w(WIDTH)-1:0]    max_err_out;
`ifdef APPROX_SWEEP_TRACE_EN
  logic                        trace_valid_out;
  logic                        trace_ready_in;
  logic [WIDTH-1:0]            trace_m_out;
  logic [WIDTH-1:0]            trace_n_out;
  logic [prod_w(WIDTH)-1:0]    trace_approx_out;
  logic [prod_w(WIDTH)-1:0]    trace_exact_out;

  modport slave (
    input  start_in, trace_ready_in,
    output busy_out, done_out, err_count_out, sum_err_out, max_err_out,
           trace_valid_out, trace_m_out, trace_n_out, trace_approx_out, trace_exact_out
  );
  modport master (
    output start_in, trace_ready_in,
    input  busy_out, done_out, err_count_out, sum_err_out, max_err_out,
           trace_valid_out, trace_m_out, trace_n_out, trace_approx_out, trace_exact_out
  );
`else
  modport slave (
    input  start_in,
    output busy_out, done_out, err_count_out, sum_err_out, max_err_out
  );
  modport master (
    output start_in,
    input  busy_out, done_out, err_count_out, sum_err_out, max_err_out
  );
`endif

endinterface

// File: rtl/approx_trunc_mult.sv
// Combinational truncated multiplier: sums partial products m[i]*n[j]*2^(i+j) with i+j >= TRUNC.
// Zero latency, no flow control; TRUNC=0 gives the exact product.
module approx_trunc_mult #(
  parameter int WIDTH = 4,
  parameter int TRUNC = 2
) (
  input  logic [WIDTH-1:0]   m_in,
  input  logic [WIDTH-1:0]   n_in,
  output logic [2*WIDTH-1:0] product_out
);

  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    product_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if ((i + j) >= TRUNC && m_in[i] && n_in[j]) begin
          product_out = product_out + (ONE << (i + j));
        end
      end
    end
  end

endmodule

// File: rtl/approx_err_sweep.sv
// Exhaustive error sweep of approx_trunc_mult: 2^(2W)+3 cycles start-to-done, 2-stage pipeline.
// With APPROX_SWEEP_TRACE_EN, trace backpressure freezes counter, pipeline and FSM together.
module approx_err_sweep
  import approx_sweep_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int TRUNC = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  approx_err_sweep_if.slave bus
);

  localparam int PW = prod_w(WIDTH);
  localparam int CW = count_w(WIDTH);
  localparam int SW = sum_w(WIDTH);
  localparam logic [PW-1:0] CNT_MAX    = '1;
  localparam logic [PW-1:0] CNT_ONE    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ERR_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [1:0]    DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t          state, state_nxt;
  logic            issue, clr, stall;
  logic [PW-1:0]   cnt;
  logic [1:0]      drain_cnt;
  logic            busy_q, done_q;
  logic [PW-1:0]   approx_c, exact_c;
  logic            s1_vld;
  logic [PW-1:0]   s1_approx, s1_exact, err;
  logic [CW-1:0]   err_count;
  logic [SW-1:0]   sum_err;
  logic [PW-1:0]   max_err;

  approx_trunc_mult #(.WIDTH(WIDTH), .TRUNC(TRUNC)) u_approx (
    .m_in(cnt[PW-1:WIDTH]), .n_in(cnt[WIDTH-1:0]), .product_out(approx_c)
  );
  approx_trunc_mult #(.WIDTH(WIDTH), .TRUNC(0)) u_exact (
    .m_in(cnt[PW-1:WIDTH]), .n_in(cnt[WIDTH-1:0]), .product_out(exact_c)
  );

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: if (bus.start_in) begin
        state_nxt = SWEEP;
        clr       = 1'b1;
      end
      SWEEP: if (!stall) begin
        issue = 1'b1;
        if (cnt == CNT_MAX) state_nxt = DRAIN;
      end
      DRAIN: if (!stall && drain_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == SWEEP) || (state_nxt == DRAIN);
      done_q <= (state == DONE);
      // counter parks on the last pair rather than wrapping
      if (clr) cnt <= '0;
      else if (issue && cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
      if (state != DRAIN) drain_cnt <= '0;
      else if (!stall) drain_cnt <= drain_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_vld    <= 1'b0;
      s1_approx <= '0;
      s1_exact  <= '0;
    end else if (!stall) begin
      s1_vld <= issue;
      if (issue) begin
        s1_approx <= approx_c;
        s1_exact  <= exact_c;
      end
    end
  end

  assign err = s1_exact - s1_approx;

  // S2 consumes the S1 pair only on the cycle it leaves S1, so a stall never double-counts
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err_count <= '0;
      sum_err   <= '0;
      max_err   <= '0;
    end else if (clr) begin
      err_count <= '0;
      sum_err   <= '0;
      max_err   <= '0;
    end else if (s1_vld && !stall && err != '0) begin
      err_count <= err_count + ERR_ONE;
      sum_err   <= sum_err + {{(SW-PW){1'b0}}, err};
      if (err > max_err) max_err <= err;
    end
  end

`ifdef APPROX_SWEEP_TRACE_EN
  logic [WIDTH-1:0] s1_m, s1_n;

  assign stall = s1_vld & ~bus.trace_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_m <= '0;
      s1_n <= '0;
    end else if (!stall && issue) begin
      s1_m <= cnt[PW-1:WIDTH];
      s1_n <= cnt[WIDTH-1:0];
    end
  end

  assign bus.trace_valid_out  = s1_vld;
  assign bus.trace_m_out      = s1_m;
  assign bus.trace_n_out      = s1_n;
  assign bus.trace_approx_out = s1_approx;
  assign bus.trace_exact_out  = s1_exact;
`else
  assign stall = 1'b0;
`endif

  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;
  assign bus.err_count_out = err_count;
  assign bus.sum_err_out   = sum_err;
  assign bus.max_err_out   = max_err;

endmodule
